alu_rr_sequencer: RTL and testbench

Hardwired control FSM that sequences the DataPath through fetch (T0–T2) and execute (T3–T5) for register-register ALU instructions (add, sub, and, or, shr, shl, ror, rol, and similar). It drives the datapath bus-source enables, register load enables, memory read strobes and the 5-bit ALU opcode, decoding fields from the datapath IR. It replaces hand-driven control sequences, so the datapath runs instructions from memory.

---
 rtl/alu_rr_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_rr_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alu_rr_sequencer.sv
// Hardwired control sequencer for register-register ALU instructions: fetch (T0-T2) then
// execute (T3-T5), driving datapath bus enables, load enables, memory strobes and ALU opcode.
module alu_rr_sequencer #(
  parameter logic [4:0]  MAX_RTYPE_OP = 5'd10,
  parameter logic [4:0]  INC_OP       = 5'b11111,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             run,
  input  logic             mem_rdy,
  input  logic [31:0]      ir_in,
  output logic             PCout,
  output logic             MARin,
  output logic             PCin,
  output logic             IncPC,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             ZlowIn,
  output logic             Zlowout,
  output logic [15:0]      Rout,
  output logic [15:0]      Rin,
  output logic [4:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StFault
  } state_e;

  state_e           state_q;
  logic             t1_first_q;
  logic [4:0]       op_q;
  logic [3:0]       ra_q;
  logic [3:0]       rc_q;
  logic [CNT_W-1:0] cnt_q;

  logic [4:0] ir_op;
  logic [3:0] ir_ra;
  logic [3:0] ir_rb;
  logic [3:0] ir_rc;
  logic       ir_legal;
  logic       unused_ir;

  assign ir_op     = ir_in[31:27];
  assign ir_ra     = ir_in[26:23];
  assign ir_rb     = ir_in[22:19];
  assign ir_rc     = ir_in[18:15];
  assign ir_legal  = (ir_op <= MAX_RTYPE_OP);
  assign unused_ir = ^ir_in[14:0];

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= StIdle;
      t1_first_q <= 1'b0;
      op_q       <= '0;
      ra_q       <= '0;
      rc_q       <= '0;
      cnt_q      <= '0;
    end else begin
      // Marks the first T1 cycle so PC is reloaded exactly once per fetch.
      t1_first_q <= (state_q == StT0);
      unique case (state_q)
        StIdle:  if (start || run) state_q <= StT0;
        StT0:    state_q <= StT1;
        StT1:    if (mem_rdy) state_q <= StT2;
        StT2:    state_q <= StT3;
        StT3: begin
          op_q    <= ir_op;
          ra_q    <= ir_ra;
          rc_q    <= ir_rc;
          state_q <= ir_legal ? StT4 : StFault;
        end
        StT4:    state_q <= StT5;
        StT5: begin
          cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_q <= run ? StT0 : StIdle;
        end
        StFault: state_q <= StFault;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    PCout   = 1'b0;
    MARin   = 1'b0;
    PCin    = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    ZlowIn  = 1'b0;
    Zlowout = 1'b0;
    Rout    = '0;
    Rin     = '0;
    alu_op  = '0;
    busy    = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      StT0: begin
        busy   = 1'b1;
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        ZlowIn = 1'b1;
        alu_op = INC_OP;
      end
      StT1: begin
        busy    = 1'b1;
        Zlowout = 1'b1;
        PCin    = t1_first_q;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      StT2: begin
        busy   = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      // IR has only just been loaded, so Rb is decoded straight from ir_in here.
      StT3: begin
        busy = 1'b1;
        if (ir_legal) begin
          Rout = 16'h0001 << ir_rb;
          Yin  = 1'b1;
        end
      end
      StT4: begin
        busy   = 1'b1;
        Rout   = 16'h0001 << rc_q;
        alu_op = op_q;
        ZlowIn = 1'b1;
      end
      StT5: begin
        busy    = 1'b1;
        Zlowout = 1'b1;
        Rin     = 16'h0001 << ra_q;
        done    = 1'b1;
      end
      StFault: illegal = 1'b1;
      default: ;
    endcase
  end

  assign instr_count = cnt_q;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed table-driven bench for alu_rr_sequencer plus a hand-written memory-wait sequence.
module tb_alu_rr_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        run = 1'b0;
  logic        mem_rdy = 1'b0;
  logic [31:0] ir_in = '0;
  logic PCout, MARin, PCin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZlowIn, Zlowout;
  logic [15:0] Rout, Rin;
  logic [4:0]  alu_op;
  logic        busy, done, illegal;
  logic [15:0] instr_count;

  alu_rr_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .run(run), .mem_rdy(mem_rdy), .ir_in(ir_in),
    .PCout(PCout), .MARin(MARin), .PCin(PCin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZlowIn(ZlowIn), .Zlowout(Zlowout),
    .Rout(Rout), .Rin(Rin), .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  // Control vector order: {PCout,MARin,PCin,IncPC,Read,MDRin,MDRout,IRin,Yin,ZlowIn,Zlowout}
  localparam logic [10:0] K_PCOUT = 11'h400, K_MARIN = 11'h200, K_PCIN = 11'h100;
  localparam logic [10:0] K_INCPC = 11'h080, K_READ = 11'h040, K_MDRIN = 11'h020;
  localparam logic [10:0] K_MDROUT = 11'h010, K_IRIN = 11'h008, K_YIN = 11'h004;
  localparam logic [10:0] K_ZIN = 11'h002, K_ZOUT = 11'h001;

  localparam logic [31:0] IR_ROR = 32'h3A1B8000;  // ror r4,r3,r7
  localparam logic [31:0] IR_ROL = 32'h421B8000;  // rol r4,r3,r7
  localparam logic [31:0] IR_ADD = 32'h18918000;  // op 3, Ra=1, Rb=2, Rc=3
  localparam logic [31:0] IR_BAD = 32'hF8000000;  // op 31

  logic [10:0] ctrl_w;
  assign ctrl_w = {PCout, MARin, PCin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZlowIn, Zlowout};

  typedef struct {
    logic        clr, st, rn, rdy;
    logic [31:0] ir;
    logic [10:0] ctrl;
    logic [15:0] ro, ri;
    logic [4:0]  alu;
    logic [2:0]  stat;  // {busy, done, illegal}
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic clr, st, rn, rdy, input logic [31:0] ir,
                              input logic [10:0] ctrl, input logic [15:0] ro, ri,
                              input logic [4:0] alu, input logic [2:0] stat,
                              input logic [15:0] cnt);
    vec_t v;
    v.clr = clr; v.st = st; v.rn = rn; v.rdy = rdy; v.ir = ir; v.ctrl = ctrl;
    v.ro = ro; v.ri = ri; v.alu = alu; v.stat = stat; v.cnt = cnt;
    return v;
  endfunction

  // Pushes the first n states (T0..T5) of a legal instruction with mem_rdy held high.
  task automatic add_legal(input logic st, rn, input logic [31:0] ir,
                           input logic [15:0] rb_oh, rc_oh, ra_oh, input logic [4:0] op,
                           input logic [15:0] cnt, input int n);
    vec_t t[6];
    t[0] = mk(0, st, rn, 1, ir, K_PCOUT | K_MARIN | K_INCPC | K_ZIN, 0, 0, 5'h1F, 3'b100, cnt);
    t[1] = mk(0, 0, rn, 1, ir, K_ZOUT | K_PCIN | K_READ | K_MDRIN, 0, 0, 0, 3'b100, cnt);
    t[2] = mk(0, 1, rn, 1, ir, K_MDROUT | K_IRIN, 0, 0, 0, 3'b100, cnt);
    t[3] = mk(0, 0, rn, 1, ir, K_YIN, rb_oh, 0, 0, 3'b100, cnt);
    t[4] = mk(0, 0, rn, 1, ir, K_ZIN, rc_oh, 0, op, 3'b100, cnt);
    t[5] = mk(0, 0, rn, 1, ir, K_ZOUT, 0, ra_oh, 0, 3'b110, cnt);
    for (int i = 0; i < n; i++) vq.push_back(t[i]);
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    int done_at, irin_at, pcin_n, read_n;

    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
    // ror then rol, single-stepped
    add_legal(1, 0, IR_ROR, 16'h0008, 16'h0080, 16'h0010, 5'b00111, 0, 6);
    vq.push_back(mk(0, 0, 0, 1, IR_ROR, 0, 0, 0, 0, 3'b000, 1));
    add_legal(1, 0, IR_ROL, 16'h0008, 16'h0080, 16'h0010, 5'b01000, 1, 6);
    vq.push_back(mk(0, 0, 0, 1, IR_ROL, 0, 0, 0, 0, 3'b000, 2));
    // Illegal opcode: fetch, T3 with no bus source, then stuck in FAULT until clear
    vq.push_back(mk(0, 1, 0, 1, IR_BAD, K_PCOUT | K_MARIN | K_INCPC | K_ZIN, 0, 0, 5'h1F,
                    3'b100, 2));
    vq.push_back(mk(0, 0, 0, 1, IR_BAD, K_ZOUT | K_PCIN | K_READ | K_MDRIN, 0, 0, 0, 3'b100, 2));
    vq.push_back(mk(0, 0, 0, 1, IR_BAD, K_MDROUT | K_IRIN, 0, 0, 0, 3'b100, 2));
    vq.push_back(mk(0, 0, 0, 1, IR_BAD, 0, 0, 0, 0, 3'b100, 2));
    vq.push_back(mk(0, 0, 0, 1, IR_BAD, 0, 0, 0, 0, 3'b001, 2));
    vq.push_back(mk(0, 1, 0, 1, IR_BAD, 0, 0, 0, 0, 3'b001, 2));
    vq.push_back(mk(0, 0, 1, 1, IR_BAD, 0, 0, 0, 0, 3'b001, 2));
    vq.push_back(mk(1, 0, 0, 1, IR_BAD, 0, 0, 0, 0, 3'b000, 0));
    // Back-to-back with run held high
    add_legal(0, 1, IR_ROR, 16'h0008, 16'h0080, 16'h0010, 5'b00111, 0, 6);
    add_legal(0, 1, IR_ROL, 16'h0008, 16'h0080, 16'h0010, 5'b01000, 1, 6);
    vq.push_back(mk(0, 0, 0, 1, IR_ROL, 0, 0, 0, 0, 3'b000, 2));
    // Clear arriving in T4, then a clean instruction
    add_legal(1, 0, IR_ROR, 16'h0008, 16'h0080, 16'h0010, 5'b00111, 2, 5);
    vq.push_back(mk(1, 0, 0, 1, IR_ROR, 0, 0, 0, 0, 3'b000, 0));
    add_legal(1, 0, IR_ADD, 16'h0004, 16'h0008, 16'h0002, 5'b00011, 0, 6);
    vq.push_back(mk(0, 0, 0, 1, IR_ADD, 0, 0, 0, 0, 3'b000, 1));

    foreach (vq[i]) begin
      clear = vq[i].clr; start = vq[i].st; run = vq[i].rn;
      mem_rdy = vq[i].rdy; ir_in = vq[i].ir;
      @(posedge clock);
      #1;
      check("ctrl", i, 32'(ctrl_w), 32'(vq[i].ctrl));
      check("Rout", i, 32'(Rout), 32'(vq[i].ro));
      check("Rin", i, 32'(Rin), 32'(vq[i].ri));
      check("alu_op", i, 32'(alu_op), 32'(vq[i].alu));
      check("busy_done_illegal", i, 32'({busy, done, illegal}), 32'(vq[i].stat));
      check("instr_count", i, 32'(instr_count), 32'(vq[i].cnt));
    end

    // Memory wait: mem_rdy low for the first three T1 cycles
    clear = 0; run = 0; ir_in = IR_ADD; mem_rdy = 0; start = 1;
    done_at = 0; irin_at = 0; pcin_n = 0; read_n = 0;
    for (int c = 1; c <= 30 && done_at == 0; c++) begin
      @(posedge clock);
      #1;
      start = 0;
      if (PCin) pcin_n++;
      if (Read) begin
        read_n++;
        if (read_n == 4) mem_rdy = 1;
      end
      if (IRin) irin_at = c;
      if (done) done_at = c;
    end
    check("wait_done_cycle", 0, 32'(done_at), 32'd9);
    check("wait_t2_cycle", 0, 32'(irin_at), 32'd6);
    check("wait_pcin_cycles", 0, 32'(pcin_n), 32'd1);
    check("wait_read_cycles", 0, 32'(read_n), 32'd4);
    @(posedge clock);
    #1;
    check("wait_end_busy", 0, 32'(busy), 32'd0);
    check("wait_end_count", 0, 32'(instr_count), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
